imm_encoder: RTL and testbench
==============================

# imm_encoder

- Instruction encoder: packs a register/immediate request into RV32I instruction words.
- Inverse of the decode-side immediate generator:
  - I-type: ADDI.
  - S-type: SW.
  - U-type: LUI.
  - Optional LI pseudo-op, which expands to LUI+ADDI.
- Sits between the boot/test-program generator and the instruction-memory write port.
- Ready/valid on both sides; one registered output stage; an out-of-range immediate is dropped and flagged.

## Interface
- Parameters: none.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_kind  in  2  0=ADDI (I), 1=SW (S), 2=LUI (U), 3=LI (pseudo).
- req_rd  in  5  destination register (ADDI, LUI, LI).
- req_rs1  in  5  source/base register (ADDI, SW).
- req_rs2  in  5  store data register (SW).
- req_imm  in  32  immediate value, signed two's complement.
- out_valid  out  1  out_instr valid.
- out_ready  in  1  downstream accepts out_instr.
- out_instr  out  32  encoded instruction.
- out_last  out  1  final word of this request.
- err  out  1  one-cycle pulse: the request was rejected.

## Operation
- States:
  - IDLE: waiting for a request.
  - LO_PEND: LUI word presented; ADDI half of LI pending.
- req_ready = (state==IDLE) && (!out_valid || out_ready).
- Range rules for an accepted request:
  - ADDI and SW: the immediate must lie in −2048..2047, otherwise error.
  - LUI: req_imm[11:0] must be 0, otherwise error; the field is req_imm[31:12].
- Encodings:
  - ADDI: opcode 0010011, funct3 000, imm[11:0] in [31:20].
  - SW: opcode 0100011, funct3 010, imm[11:5] in [31:25], imm[4:0] in [11:7].
  - LUI: opcode 0110111.
- LI:
  - Immediate fits in 12 signed bits → single word, ADDI rd, x0, imm.
  - Else hi = (imm + 0x800) >> 12 (32-bit wrap), giving LUI rd, hi.
  - Then, if imm[11:0] != 0: ADDI rd, rd, imm[11:0]; go to LO_PEND with out_last=0 on the LUI word.
  - If imm[11:0] == 0: LUI only, out_last=1.
- LO_PEND: when the LUI word handshakes, the ADDI word is loaded with out_last=1, then the state returns to IDLE.
- Error path: the request is consumed, no out_valid, err=1 the following cycle, state stays IDLE.
- out_instr, out_last held stable while out_valid && !out_ready.

## Timing
- Reset values:
  - out_valid=0, out_instr=0, out_last=0, err=0, state=IDLE.
  - req_ready=1 after reset release.
- Latency: word appears on out_instr one cycle after request acceptance.
- Throughput:
  - Single-word requests: 1 word/cycle with out_ready held high.
  - LI with two words: 2 cycles; req_ready=0 while in LO_PEND.
- Simultaneous out handshake and new accept in the same cycle: the register reloads with no bubble.
- Reset mid-LI discards the pending ADDI.

## Configuration
- IMM_ENC_LI_EN defined: kind 3 (LI) behaves as above.
- IMM_ENC_LI_EN undefined:
  - LO_PEND state is absent.
  - Kind 3 is treated as an error: err pulse, no output.
  - out_last is constant 1.

## Structure
- Shared package minirv_isa_pkg:
  - Opcode constants OP_IMM, OP_STORE, OP_LUI.
  - funct3 constants F3_ADDI, F3_SW.
  - The req_kind enum.
- Sub-module imm_pack: combinational packer with format select, rd, rs1, rs2, and a 32-bit immediate in; the 32-bit word out. It is instantiated once; the FSM drives its inputs.

## Test plan
- ADDI rd=5 rs1=0 imm=0xFFFFFFFF → out_instr=0xFFF00293, out_last=1, err=0, one cycle after accept.
- SW rs1=2 rs2=6 imm=8 → 0x00612423, out_last=1.
- LI rd=10 imm=0x12345FFF:
  - First word 0x12346537, out_last=0.
  - Second word 0xFFF50513, out_last=1.
  - req_ready=0 between the two words.
- Single-word and reject cases:
  - LI rd=1 imm=0x00001000 → single 0x000010B7, out_last=1.
  - LI rd=1 imm=−5 → single 0xFFB00093.
  - ADDI imm=0x800 → err pulse 1 cycle, no out_valid, req_ready high next cycle.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles during the LI LUI word → out_instr stable, no new accept.
  - Assert rst_n=0 in LO_PEND → out_valid=0 and state IDLE immediately; no ADDI emitted after release.
- With IMM_ENC_LI_EN undefined: LI request → err pulse, no output.

Source files
------------

// File: rtl/minirv_isa_pkg.sv
// Shared RV32I encoding constants, request kinds and packer formats for the
// minimal instruction encoder.
package minirv_isa_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SW   = 3'b010;

    typedef enum logic [1:0] {
        KIND_ADDI = 2'd0,
        KIND_SW   = 2'd1,
        KIND_LUI  = 2'd2,
        KIND_LI   = 2'd3
    } req_kind_e;

    typedef enum logic [1:0] {
        FMT_I = 2'd0,
        FMT_S = 2'd1,
        FMT_U = 2'd2
    } fmt_e;

    // True when the 32-bit value is representable as a signed 12-bit immediate.
    function automatic logic fits_simm12(input logic [31:0] v);
        return (&v[31:11]) || !(|v[31:11]);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I word packer: ADDI (I), SW (S) or LUI (U) from register
// fields and a 32-bit immediate.
module imm_pack
    import minirv_isa_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (fmt)
            FMT_I:   word = {imm[11:0], rs1, F3_ADDI, rd, OP_IMM};
            FMT_S:   word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
            FMT_U:   word = {imm[31:12], rd, OP_LUI};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Ready/valid RV32I instruction encoder with one registered output stage.
// Define IMM_ENC_LI_EN to enable the LI pseudo-op (LUI+ADDI expansion).
module imm_encoder
    import minirv_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err
);

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        err_q, err_d;
    logic        in_idle, accept, req_ok;
    fmt_e        pk_fmt;
    logic [4:0]  pk_rd, pk_rs1;
    logic [31:0] pk_imm, pk_word;

`ifdef IMM_ENC_LI_EN
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LO_PEND = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        out_last_q, out_last_d, word_last;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic [11:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_imm;

    assign in_idle  = (state_q == ST_IDLE);
    // Rounding by 0x800 compensates for the sign extension of the ADDI half.
    assign hi_imm   = (req_imm + 32'h0000_0800) & 32'hFFFF_F000;
    assign out_last = out_last_q;
`else
    assign in_idle  = 1'b1;
    assign out_last = 1'b1;
`endif

    assign req_ready = in_idle && (!out_valid_q || out_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        pk_fmt = FMT_I;
        pk_rd  = req_rd;
        pk_rs1 = req_rs1;
        pk_imm = req_imm;
        req_ok = 1'b0;
`ifdef IMM_ENC_LI_EN
        word_last = 1'b1;
`endif
        case (req_kind_e'(req_kind))
            KIND_ADDI: req_ok = fits_simm12(req_imm);
            KIND_SW: begin
                pk_fmt = FMT_S;
                req_ok = fits_simm12(req_imm);
            end
            KIND_LUI: begin
                pk_fmt = FMT_U;
                req_ok = (req_imm[11:0] == 12'd0);
            end
            KIND_LI: begin
`ifdef IMM_ENC_LI_EN
                req_ok = 1'b1;
                if (fits_simm12(req_imm)) begin
                    pk_rs1 = 5'd0;
                end else begin
                    pk_fmt    = FMT_U;
                    pk_imm    = hi_imm;
                    word_last = (req_imm[11:0] == 12'd0);
                end
`else
                req_ok = 1'b0;
`endif
            end
            default: req_ok = 1'b0;
        endcase
`ifdef IMM_ENC_LI_EN
        // While the LUI word is presented, the packer prepares ADDI rd, rd, lo.
        if (state_q == ST_LO_PEND) begin
            pk_fmt = FMT_I;
            pk_rd  = pend_rd_q;
            pk_rs1 = pend_rd_q;
            pk_imm = {{20{pend_lo_q[11]}}, pend_lo_q};
        end
`endif
    end

    imm_pack u_pack (
        .fmt  (pk_fmt),
        .rd   (pk_rd),
        .rs1  (pk_rs1),
        .rs2  (req_rs2),
        .imm  (pk_imm),
        .word (pk_word)
    );

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_instr_d = out_instr_q;
        err_d       = 1'b0;
`ifdef IMM_ENC_LI_EN
        out_last_d = out_last_q;
        state_d    = state_q;
        pend_rd_d  = pend_rd_q;
        pend_lo_d  = pend_lo_q;
        if (state_q == ST_LO_PEND && out_ready) begin
            out_valid_d = 1'b1;
            out_instr_d = pk_word;
            out_last_d  = 1'b1;
            state_d     = ST_IDLE;
        end
`endif
        if (accept) begin
            if (req_ok) begin
                out_valid_d = 1'b1;
                out_instr_d = pk_word;
`ifdef IMM_ENC_LI_EN
                out_last_d = word_last;
                if (!word_last) begin
                    state_d   = ST_LO_PEND;
                    pend_rd_d = req_rd;
                    pend_lo_d = req_imm[11:0];
                end
`endif
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            err_q       <= 1'b0;
`ifdef IMM_ENC_LI_EN
            out_last_q  <= 1'b0;
            state_q     <= ST_IDLE;
            pend_rd_q   <= '0;
            pend_lo_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            err_q       <= err_d;
`ifdef IMM_ENC_LI_EN
            out_last_q  <= out_last_d;
            state_q     <= state_d;
            pend_rd_q   <= pend_rd_d;
            pend_lo_q   <= pend_lo_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder; LI scenarios are selected by IMM_ENC_LI_EN.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef IMM_ENC_LI_EN
    localparam bit LI_EN = 1'b1;
`else
    localparam bit LI_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_kind  (req_kind),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last),
        .err       (err)
    );

    // Reference encodings built arithmetically from the RV32I field positions.
    function automatic logic [31:0] ref_addi(input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] imm);
        return (imm % 4096) * 1048576 + rs1 * 32768 + rd * 128 + 19;
    endfunction

    function automatic logic [31:0] ref_sw(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        logic [31:0] lo;
        lo = imm % 4096;
        return (lo / 32) * 33554432 + rs2 * 1048576 + rs1 * 32768 + 2 * 4096 + (lo % 32) * 128 + 35;
    endfunction

    function automatic logic [31:0] ref_lui(input logic [31:0] rd, input logic [31:0] imm);
        return (imm / 4096) * 4096 + rd * 128 + 55;
    endfunction

    // n = number of words emitted (0 means rejected).
    task automatic ref_model(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm,
                             output int n, output logic [31:0] w0, output logic [31:0] w1);
        int  s;
        bit  fits;
        logic [31:0] hi;
        s    = $signed(imm);
        fits = (s >= -2048) && (s <= 2047);
        n = 0; w0 = '0; w1 = '0;
        case (kind)
            2'd0: if (fits) begin n = 1; w0 = ref_addi({27'd0, rd}, {27'd0, rs1}, imm); end
            2'd1: if (fits) begin n = 1; w0 = ref_sw({27'd0, rs1}, {27'd0, rs2}, imm); end
            2'd2: if (imm % 4096 == 0) begin n = 1; w0 = ref_lui({27'd0, rd}, imm); end
            default: begin
                if (LI_EN) begin
                    if (fits) begin
                        n = 1; w0 = ref_addi({27'd0, rd}, 32'd0, imm);
                    end else begin
                        hi = (imm + 32'd2048) / 4096;
                        w0 = ref_lui({27'd0, rd}, hi * 4096);
                        if (imm % 4096 != 0) begin
                            n = 2; w1 = ref_addi({27'd0, rd}, {27'd0, rd}, imm);
                        end else begin
                            n = 1;
                        end
                    end
                end
            end
        endcase
    endtask

    // Presents a request with out_ready=1 until accepted; returns just after the accepting edge.
    task automatic do_req(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, output bit ok);
        @(negedge clk);
        req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1; out_ready = 1'b1;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !req_ready; i++) begin
            @(negedge clk); #1;
        end
        if (req_ready) begin
            ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_kind = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (out_last !== !LI_EN) begin errors++; $display("FAIL reset_out_last: got %b expected %b", out_last, !LI_EN); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        $display("reset: done");
    endtask

    task automatic test_single_words();
        logic [1:0]  k [6]  = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
        logic [4:0]  rd [6] = '{5'd5, 5'd0, 5'd31, 5'd1, 5'd0, 5'd3};
        logic [4:0]  r1 [6] = '{5'd0, 5'd2, 5'd17, 5'd9, 5'd31, 5'd0};
        logic [4:0]  r2 [6] = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd19, 5'd0};
        logic [31:0] im [6] = '{32'hFFFF_FFFF, 32'd8, 32'd2047, 32'hFFFF_F800, 32'hFFFF_F800, 32'hABCD_E000};
        logic [31:0] fixed [2] = '{32'hFFF0_0293, 32'h0061_2423};
        logic [31:0] w0, w1, exp;
        int n;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            ref_model(k[i], rd[i], r1[i], r2[i], im[i], n, w0, w1);
            exp = (i < 2) ? fixed[i] : w0;
            do_req(k[i], rd[i], r1[i], r2[i], im[i], ok);
            @(negedge clk); #1;
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_accept[%0d]: got %b expected 1", i, ok); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_instr !== exp) begin errors++; $display("FAIL single_instr[%0d]: got %h expected %h", i, out_instr, exp); end
            checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL single_last[%0d]: got %b expected 1", i, out_last); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err[%0d]: got %b expected 0", i, err); end
            $display("single: kind=%0d imm=%h word=%h", k[i], im[i], out_instr);
        end
    endtask

    task automatic test_reject();
        logic [1:0]  k  [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1};
        logic [31:0] im [5] = '{32'h0000_0800, 32'hFFFF_F7FF, 32'h0000_0800, 32'h0001_2345, 32'h8000_0000};
        bit ok;
        for (int i = 0; i < 5; i++) begin
            do_req(k[i], 5'd4, 5'd5, 5'd6, im[i], ok);
            @(negedge clk); #1;
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL reject_err[%0d]: got %b expected 1", i, err); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reject_valid[%0d]: got %b expected 0", i, out_valid); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reject_ready[%0d]: got %b expected 1", i, req_ready); end
            @(negedge clk); #1;
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL reject_err_pulse[%0d]: got %b expected 0", i, err); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reject_no_word[%0d]: got %b expected 0", i, out_valid); end
            $display("reject: kind=%0d imm=%h err pulse seen", k[i], im[i]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] first, w1, second, dummy;
        int n;
        bit ok;
        if (LI_EN) begin
            first = 32'h1234_6537;
            do_req(2'd3, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, ok);
        end else begin
            ref_model(2'd0, 5'd7, 5'd3, 5'd0, 32'h123, n, first, w1);
            do_req(2'd0, 5'd7, 5'd3, 5'd0, 32'h123, ok);
        end
        ref_model(2'd0, 5'd1, 5'd2, 5'd0, 32'd5, n, second, dummy);
        req_kind = 2'd0; req_rd = 5'd1; req_rs1 = 5'd2; req_rs2 = 5'd0; req_imm = 32'd5;
        req_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
            checks++; if (out_instr !== first) begin errors++; $display("FAIL bp_stable[%0d]: got %h expected %h", c, out_instr, first); end
            checks++; if (out_last !== !LI_EN) begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", c, out_last, !LI_EN); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_no_accept[%0d]: got %b expected 0", c, req_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== !LI_EN) begin errors++; $display("FAIL bp_release_ready: got %b expected %b", req_ready, !LI_EN); end
        if (LI_EN) begin
            @(negedge clk); #1;
            checks++; if (out_instr !== 32'hFFF5_0513) begin errors++; $display("FAIL bp_li_second: got %h expected fff50513", out_instr); end
            checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL bp_li_second_last: got %b expected 1", out_last); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_li_ready: got %b expected 1", req_ready); end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_instr !== second) begin errors++; $display("FAIL bp_next_word: got v=%b %h expected v=1 %h", out_valid, out_instr, second); end
        $display("backpressure: held %h for 3 cycles, then %h", first, second);
    endtask

`ifdef IMM_ENC_LI_EN
    task automatic test_li();
        logic [31:0] im  [3] = '{32'h1234_5FFF, 32'h0000_1000, 32'hFFFF_FFFB};
        logic [4:0]  rd  [3] = '{5'd10, 5'd1, 5'd1};
        logic [31:0] w0x [3] = '{32'h1234_6537, 32'h0000_10B7, 32'hFFB0_0093};
        bit ok;
        for (int i = 0; i < 3; i++) begin
            do_req(2'd3, rd[i], 5'd0, 5'd0, im[i], ok);
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_instr !== w0x[i]) begin errors++; $display("FAIL li_first[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_instr, w0x[i]); end
            checks++; if (out_last !== (i != 0)) begin errors++; $display("FAIL li_first_last[%0d]: got %b expected %b", i, out_last, i != 0); end
            if (i == 0) begin
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL li_ready_between: got %b expected 0", req_ready); end
            end
            @(negedge clk); #1;
            if (i == 0) begin
                checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFFF5_0513 || out_last !== 1'b1) begin errors++; $display("FAIL li_second: got v=%b %h last=%b expected v=1 fff50513 last=1", out_valid, out_instr, out_last); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL li_single_extra[%0d]: got %b expected 0", i, out_valid); end
            end
            $display("li: imm=%h first=%h", im[i], w0x[i]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_li();
        bit ok;
        do_req(2'd3, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, ok);
        out_ready = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_li_valid: got %b expected 0", out_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_li_no_addi[%0d]: got %b expected 0", c, out_valid); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_li_ready[%0d]: got %b expected 1", c, req_ready); end
        end
        $display("reset_mid_li: pending ADDI discarded");
    endtask
`else
    task automatic test_li_disabled();
        logic [31:0] im [2] = '{32'h1234_5FFF, 32'hFFFF_FFFB};
        bit ok;
        for (int i = 0; i < 2; i++) begin
            do_req(2'd3, 5'd1, 5'd0, 5'd0, im[i], ok);
            @(negedge clk); #1;
            checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL li_disabled[%0d]: got err=%b v=%b expected err=1 v=0", i, err, out_valid); end
            @(negedge clk); #1;
            checks++; if (err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL li_disabled_after[%0d]: got err=%b v=%b expected 0 0", i, err, out_valid); end
            $display("li_disabled: imm=%h rejected", im[i]);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_w[$];
        bit          exp_l[$];
        logic [31:0] bnd [6] = '{32'h7FF, 32'h800, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'h0, 32'h7FFF_F800};
        logic [31:0] w0, w1, ew;
        bit          el, err_exp, err_next, accepted;
        int          n, words, rejects;
        err_exp = 1'b0; words = 0; rejects = 0;
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (!req_valid && ($urandom % 4 != 0)) begin
                req_kind = 2'($urandom % 4);
                req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
                case ($urandom % 4)
                    0: req_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                    1: req_imm = bnd[$urandom % 6];
                    2: req_imm = $urandom & 32'hFFFF_F000;
                    default: req_imm = $urandom;
                endcase
                req_valid = 1'b1;
            end
            out_ready = ($urandom % 4 != 0);
            #1;
            checks++; if (err !== err_exp) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", cyc, err, err_exp); end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_w.size() == 0) begin
                    errors++; $display("FAIL rand_spurious[%0d]: got word %h expected none", cyc, out_instr);
                end else begin
                    ew = exp_w.pop_front(); el = exp_l.pop_front();
                    if (out_instr !== ew || out_last !== el) begin
                        errors++; $display("FAIL rand_word[%0d]: got %h last=%b expected %h last=%b", cyc, out_instr, out_last, ew, el);
                    end
                    words++;
                end
            end
            err_next = 1'b0; accepted = 1'b0;
            if (req_valid && req_ready) begin
                accepted = 1'b1;
                ref_model(req_kind, req_rd, req_rs1, req_rs2, req_imm, n, w0, w1);
                if (n == 0) begin
                    err_next = 1'b1; rejects++;
                end else begin
                    exp_w.push_back(w0); exp_l.push_back(!LI_EN || n == 1);
                    if (n == 2) begin exp_w.push_back(w1); exp_l.push_back(1'b1); end
                end
            end
            err_exp = err_next;
            @(posedge clk); #1;
            if (accepted) req_valid = 1'b0;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_w.size() != 0; c++) begin
            @(negedge clk); #1;
            if (out_valid) begin
                ew = exp_w.pop_front(); el = exp_l.pop_front();
                checks++; if (out_instr !== ew || out_last !== el) begin errors++; $display("FAIL rand_drain: got %h last=%b expected %h last=%b", out_instr, out_last, ew, el); end
                words++;
            end
        end
        @(negedge clk); #1;
        checks++; if (exp_w.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL rand_leftover: got %0d pending v=%b expected 0 pending v=0", exp_w.size(), out_valid); end
        $display("random: %0d words, %0d rejects", words, rejects);
    endtask

    initial begin
        test_reset();
        test_single_words();
        test_reject();
        test_backpressure();
`ifdef IMM_ENC_LI_EN
        test_li();
        test_reset_mid_li();
`else
        test_li_disabled();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
